// File: rtl/alu_simple.sv
// alu_simple: registered single-cycle integer ALU.
// The operation is decoded combinationally from the current inputs. The result
// and the status flags are registered once per clock.
module alu_simple #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,    // active-high synchronous reset despite the name
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [3:0]       aluop_in,
    output logic [WIDTH-1:0] rd,
    output logic [2:0]       flag        // {ILLEGAL, OVF, ZERO}
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SEXT = 4'b1001;
    localparam logic [3:0] OP_ZEXT = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NEG  = 4'b1100;

    // Smallest negative value: the one operand whose negation overflows.
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Signed overflow of a + b: same-sign operands whose result sign flips.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a - b: opposite-sign operands, result sign differs from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    logic signed [WIDTH-1:0] rs1_s;
    logic signed [WIDTH-1:0] rs2_s;
    logic        [SHW-1:0]   shamt;
    logic        [WIDTH-1:0] sum;
    logic        [WIDTH-1:0] diff;
    logic        [WIDTH-1:0] neg;
    logic signed [WIDTH-1:0] sra_s;

    logic [WIDTH-1:0] rd_d;
    logic [WIDTH-1:0] rd_q;
    logic             ovf_d;
    logic             illegal_d;
    logic [2:0]       flag_d;
    logic [2:0]       flag_q;

    assign rs1_s = $signed(rs1);
    assign rs2_s = $signed(rs2);
    assign shamt = rs2[SHW-1:0];
    assign sum   = rs1 + rs2;
    assign diff  = rs1 - rs2;
    assign neg   = (~rs1) + {{(WIDTH-1){1'b0}}, 1'b1};
    assign sra_s = rs1_s >>> shamt;

    // Decode the opcode into the next result, overflow and illegal indication.
    always_comb begin
        rd_d      = '0;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        case (aluop_in)
            OP_ADD: begin
                rd_d  = sum;
                ovf_d = add_ovf(rs1[WIDTH-1], rs2[WIDTH-1], sum[WIDTH-1]);
            end
            OP_SUB: begin
                rd_d  = diff;
                ovf_d = sub_ovf(rs1[WIDTH-1], rs2[WIDTH-1], diff[WIDTH-1]);
            end
            OP_AND:  rd_d = rs1 & rs2;
            OP_SLL:  rd_d = rs1 << shamt;
            OP_SRL:  rd_d = rs1 >> shamt;
            OP_SRA:  rd_d = $unsigned(sra_s);
            OP_SLT:  rd_d = {{(WIDTH-1){1'b0}}, (rs1_s < rs2_s)};
            OP_SLTU: rd_d = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            OP_SEXT: rd_d = {{HALF{rs1[HALF-1]}}, rs1[HALF-1:0]};
            OP_ZEXT: rd_d = {{HALF{1'b0}}, rs1[HALF-1:0]};
            OP_XOR:  rd_d = rs1 ^ rs2;
            OP_NEG: begin
                rd_d  = neg;
                ovf_d = (rs1 == MIN_NEG);
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // ZERO is only meaningful on a legal op; illegal ops report 3'b100 alone.
    assign flag_d = {illegal_d, ovf_d, (~illegal_d) & (rd_d == '0)};

    // Register the result and flags; reset clears both and overrides any op.
    always_ff @(posedge clk) begin
        if (resetn) begin
            rd_q   <= '0;
            flag_q <= 3'b000;
        end else begin
            rd_q   <= rd_d;
            flag_q <= flag_d;
        end
    end

    assign rd   = rd_q;
    assign flag = flag_q;

endmodule

// File: tb/tb_alu_simple.sv
// tb_alu_simple: directed checks of alu_simple plus a random regression of
// AND/XOR/ADD/SUB against a small reference model, with a mid-run reset.
module tb_alu_simple;

    localparam logic [3:0] ADD  = 4'b0001;
    localparam logic [3:0] SUB  = 4'b0010;
    localparam logic [3:0] AND_ = 4'b0011;
    localparam logic [3:0] SLL  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b0110;
    localparam logic [3:0] SLT  = 4'b0111;
    localparam logic [3:0] SLTU = 4'b1000;
    localparam logic [3:0] SEXT = 4'b1001;
    localparam logic [3:0] ZEXT = 4'b1010;
    localparam logic [3:0] XOR_ = 4'b1011;
    localparam logic [3:0] NEG  = 4'b1100;

    logic        clk;
    logic        resetn;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic [3:0]  aluop_in;
    logic [15:0] rd;
    logic [2:0]  flag;

    int nvec;
    int nerr;

    alu_simple #(.WIDTH(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rs1      (rs1),
        .rs2      (rs2),
        .aluop_in (aluop_in),
        .rd       (rd),
        .flag     (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare registered outputs against expected values.
    task automatic check(input string tag, input logic [15:0] exp_rd, input logic [2:0] exp_flag);
        nvec++;
        assert (rd === exp_rd && flag === exp_flag)
        else begin
            nerr++;
            $error("FAIL %s: observed rd=%h flag=%b, expected rd=%h flag=%b",
                   tag, rd, flag, exp_rd, exp_flag);
        end
    endtask

    // Drive one op, let it be captured on the next edge, then check 1 ns later.
    task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_rd, input logic [2:0] exp_flag);
        aluop_in = op;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        check(tag, exp_rd, exp_flag);
    endtask

    // Reference for the random regression ops, overflow from integer range.
    task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [2:0] f);
        int s;
        logic ovf;
        ovf = 1'b0;
        case (op)
            ADD: begin
                s = int'($signed(a)) + int'($signed(b));
                r = a + b;
                ovf = (s > 32767) || (s < -32768);
            end
            SUB: begin
                s = int'($signed(a)) - int'($signed(b));
                r = a - b;
                ovf = (s > 32767) || (s < -32768);
            end
            AND_: r = a & b;
            default: r = a ^ b;
        endcase
        f = {1'b0, ovf, (r == 16'h0000)};
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] er;
        logic [2:0]  ef;
        logic [3:0]  ops [4];

        nvec     = 0;
        nerr     = 0;
        resetn   = 1'b1;
        rs1      = 16'h0000;
        rs2      = 16'h0000;
        aluop_in = SUB;

        // Reset hold with random operands and SUB selected.
        for (int i = 0; i < 10; i++) begin
            run("reset_hold", SUB, 16'($urandom), 16'($urandom), 16'h0000, 3'b000);
        end

        resetn = 1'b0;

        // Illegal opcodes.
        run("illegal_1111", 4'b1111, 16'd1834, 16'd3745, 16'h0000, 3'b100);
        run("illegal_0000", 4'b0000, 16'd1834, 16'd3745, 16'h0000, 3'b100);
        run("illegal_1101", 4'b1101, 16'h0000, 16'h0000, 16'h0000, 3'b100);

        // Arithmetic with wrap and overflow.
        run("add_ovf",   ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b010);
        run("add_wrap",  ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b001);
        run("sub_zero",  SUB, 16'h0005, 16'h0005, 16'h0000, 3'b001);
        run("sub_ovf",   SUB, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
        run("neg_min",   NEG, 16'h8000, 16'h1234, 16'h8000, 3'b010);
        run("neg_one",   NEG, 16'h0001, 16'h0000, 16'hFFFF, 3'b000);
        run("neg_zero",  NEG, 16'h0000, 16'h0000, 16'h0000, 3'b001);

        // Shifts: rs2 = 0x0013 uses only the low 4 bits (amount 3).
        run("sll", SLL, 16'h00AB, 16'h0013, 16'h0558, 3'b000);
        run("srl", SRL, 16'h8010, 16'h0013, 16'h1002, 3'b000);
        run("sra", SRA, 16'h8010, 16'h0013, 16'hF002, 3'b000);
        run("sra_pos", SRA, 16'h4010, 16'h0003, 16'h0802, 3'b000);

        // Compare / extend / logic.
        run("slt",    SLT,  16'hFFFF, 16'h0001, 16'h0001, 3'b000);
        run("sltu",   SLTU, 16'hFFFF, 16'h0001, 16'h0000, 3'b001);
        run("sltu_t", SLTU, 16'h0001, 16'hFFFF, 16'h0001, 3'b000);
        run("sext_n", SEXT, 16'h00AC, 16'hFFFF, 16'hFFAC, 3'b000);
        run("sext_p", SEXT, 16'h002C, 16'h0000, 16'h002C, 3'b000);
        run("zext",   ZEXT, 16'h12AC, 16'h5555, 16'h00AC, 3'b000);
        run("and",    AND_, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b000);
        run("xor",    XOR_, 16'hA5A5, 16'hA5A5, 16'h0000, 3'b001);

        // Random regression against the reference model.
        ops[0] = AND_;
        ops[1] = XOR_;
        ops[2] = ADD;
        ops[3] = SUB;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 100; i++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                model(ops[k], a, b, er, ef);
                run("random", ops[k], a, b, er, ef);
            end
        end

        // Mid-run reset for 2 cycles overrides a pending op.
        resetn = 1'b1;
        run("midreset_0", ADD, 16'h1234, 16'h1111, 16'h0000, 3'b000);
        run("midreset_1", SUB, 16'h0001, 16'h0002, 16'h0000, 3'b000);
        resetn = 1'b0;
        run("post_reset",  ADD, 16'h1234, 16'h1111, 16'h2345, 3'b000);
        run("post_reset2", SUB, 16'h0001, 16'h0002, 16'hFFFF, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
